// File: rtl/dsi_frame_sequencer_if.sv
// rtl/dsi_frame_sequencer_if.sv - command handshake between the frame sequencer and the D-PHY TX byte engine
interface dsi_frame_sequencer_if;
    logic [7:0] command_o;
    logic       write_cmd_o;
    logic       finish_i;

    modport master (
        output command_o,
        output write_cmd_o,
        input  finish_i
    );

    modport slave (
        input  command_o,
        input  write_cmd_o,
        output finish_i
    );
endinterface

// File: rtl/dsi_frame_sequencer.sv
// rtl/dsi_frame_sequencer.sv - DSI panel session sequencer: init, first-line and next-line commands
// with setup gap, fixed-width strobe, finish-level handshake and acknowledge timeout.
module dsi_frame_sequencer #(
    parameter int         LINE_MAX       = 240,
    parameter int         LINE_W         = 10,
    parameter logic [7:0] CMD_INIT       = 8'h89,
    parameter logic [7:0] CMD_LINE_FIRST = 8'h3F,
    parameter logic [7:0] CMD_LINE_NEXT  = 8'h6B,
    parameter logic [7:0] CMD_TP_FIRST   = 8'hCF,
    parameter logic [7:0] CMD_TP_NEXT    = 8'hD9,
    parameter int         GAP_CYCLES     = 50,
    parameter int         STROBE_CYCLES  = 5,
    parameter int         ACK_TIMEOUT    = 1024
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic                          continuous_i,
    input  logic                          stop_i,
    input  logic                          test_pattern_i,
    input  logic                          skip_init_i,
    dsi_frame_sequencer_if.master         eng,
    output logic                          busy_o,
    output logic                          frame_done_o,
    output logic [LINE_W-1:0]             line_count_o,
    output logic [15:0]                   frame_count_o,
    output logic                          error_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_STROBE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_ERROR
    } state_e;

    typedef enum logic [1:0] {
        PH_INIT,
        PH_FIRST,
        PH_NEXT
    } phase_e;

    // One shared counter serves the gap, strobe and acknowledge windows.
    localparam int CNT_MAX_GS = (GAP_CYCLES > STROBE_CYCLES) ? GAP_CYCLES : STROBE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_GS > ACK_TIMEOUT) ? CNT_MAX_GS : ACK_TIMEOUT;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [LINE_W-1:0] LINE_LAST   = LINE_W'(LINE_MAX - 1);

    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [15:0]        frame_q, frame_d;
    logic               tp_q, tp_d;
    logic [7:0]         cmd_q, cmd_d;
    logic               fdone_q, fdone_d;

    function automatic logic [7:0] cmd_code(input phase_e ph, input logic tp);
        logic [7:0] code;
        case (ph)
            PH_INIT:  code = CMD_INIT;
            PH_FIRST: code = tp ? CMD_TP_FIRST : CMD_LINE_FIRST;
            PH_NEXT:  code = tp ? CMD_TP_NEXT : CMD_LINE_NEXT;
            default:  code = CMD_INIT;
        endcase
        return code;
    endfunction

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            phase_q <= PH_INIT;
            cnt_q   <= '0;
            line_q  <= '0;
            frame_q <= 16'h0000;
            tp_q    <= 1'b0;
            cmd_q   <= 8'h00;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            tp_q    <= tp_d;
            cmd_q   <= cmd_d;
            fdone_q <= fdone_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        frame_d = frame_q;
        tp_d    = tp_q;
        cmd_d   = cmd_q;
        fdone_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (start_i) begin
                    state_d = ST_GAP;
                    phase_d = skip_init_i ? PH_FIRST : PH_INIT;
                    cnt_d   = '0;
                    line_d  = '0;
                    frame_d = 16'h0000;
                    tp_d    = test_pattern_i;
                    cmd_d   = skip_init_i ? cmd_code(PH_FIRST, test_pattern_i) : CMD_INIT;
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_STROBE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    state_d = ST_WAIT_ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // A finish low seen only here counts as the engine accepting the command.
            ST_WAIT_ACK: begin
                if (!eng.finish_i) begin
                    state_d = ST_WAIT_DONE;
                    cnt_d   = '0;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = ST_ERROR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                if (eng.finish_i) begin
                    cnt_d = '0;
                    if (phase_q == PH_INIT) begin
                        state_d = ST_GAP;
                        phase_d = PH_FIRST;
                        line_d  = '0;
                        cmd_d   = cmd_code(PH_FIRST, tp_q);
                    end else if (line_q < LINE_LAST) begin
                        state_d = ST_GAP;
                        phase_d = PH_NEXT;
                        line_d  = line_q + LINE_W'(1);
                        cmd_d   = cmd_code(PH_NEXT, tp_q);
                    end else begin
                        fdone_d = 1'b1;
                        frame_d = frame_q + 16'd1;
                        if (continuous_i && !stop_i) begin
                            state_d = ST_GAP;
                            phase_d = PH_FIRST;
                            line_d  = '0;
                            tp_d    = test_pattern_i;
                            cmd_d   = cmd_code(PH_FIRST, test_pattern_i);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign eng.command_o   = cmd_q;
    assign eng.write_cmd_o = (state_q == ST_STROBE);
    assign busy_o          = (state_q != ST_IDLE) && (state_q != ST_ERROR);
    assign error_o         = (state_q == ST_ERROR);
    assign frame_done_o    = fdone_q;
    assign line_count_o    = line_q;
    assign frame_count_o   = frame_q;

endmodule
